// File: rtl/aes_cipher_sched_pkg.sv
// Shared types and constants for the AES cipher sequencing controller.
// FSM encodings, block width and the legal key-length/round-count pairs.
package aes_cipher_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  localparam int BLOCK_W = 128;
  localparam int CNT_W   = 4;

  // AES-128/192/256 are the only valid key-length/round-count pairings.
  function automatic bit nk_nr_legal(input int nk, input int nr);
    return ((nk == 4) && (nr == 10)) ||
           ((nk == 6) && (nr == 12)) ||
           ((nk == 8) && (nr == 14));
  endfunction

  function automatic bit settle_legal(input int settle);
    return (settle >= 1) && (settle <= 15);
  endfunction

endpackage

// File: rtl/aes_cipher_sched_if.sv
// Bundle of requester, cipher-core and response signals for aes_cipher_sched.
// slave is the scheduler side, master is the host/cipher side.
interface aes_cipher_sched_if
  import aes_cipher_sched_pkg::*;
#(
  parameter int NK = 8
);

  logic                 i_req0_valid;
  logic                 o_req0_ready;
  logic [32*NK-1:0]     i_req0_key;
  logic [BLOCK_W-1:0]   i_req0_data;

  logic                 i_req1_valid;
  logic                 o_req1_ready;
  logic [32*NK-1:0]     i_req1_key;
  logic [BLOCK_W-1:0]   i_req1_data;

  logic [32*NK-1:0]     o_cph_key;
  logic [BLOCK_W-1:0]   o_cph_data;
  logic [BLOCK_W-1:0]   i_cph_data;

  logic                 o_resp_valid;
  logic                 i_resp_ready;
  logic [BLOCK_W-1:0]   o_resp_data;
  logic                 o_resp_id;
  logic                 o_busy;

  modport slave (
    input  i_req0_valid, i_req0_key, i_req0_data,
    input  i_req1_valid, i_req1_key, i_req1_data,
    input  i_cph_data, i_resp_ready,
    output o_req0_ready, o_req1_ready,
    output o_cph_key, o_cph_data,
    output o_resp_valid, o_resp_data, o_resp_id, o_busy
  );

  modport master (
    output i_req0_valid, i_req0_key, i_req0_data,
    output i_req1_valid, i_req1_key, i_req1_data,
    output i_cph_data, i_resp_ready,
    input  o_req0_ready, o_req1_ready,
    input  o_cph_key, o_cph_data,
    input  o_resp_valid, o_resp_data, o_resp_id, o_busy
  );

endinterface

// File: rtl/aes_rr_arb.sv
// Combinational 2-way round-robin arbiter; the last-grant history lives in the parent.
// A lone valid always wins; on contention the requester not granted last time wins.
module aes_rr_arb (
  input  logic [1:0] valid,
  input  logic       last_grant,
  input  logic       enable,
  output logic [1:0] grant
);

  for (genvar gi = 0; gi < 2; gi++) begin : g_grant
    assign grant[gi] = enable & valid[gi] &
                       (~valid[1-gi] | (last_grant != 1'(gi)));
  end

endmodule

// File: rtl/aes_cipher_sched.sv
// Arbitrates two requesters onto a shared combinational AES core, holds its inputs for
// SETTLE_CYCLES, then returns the ciphertext. Optional macro: AES_SCHED_ZEROIZE_EN.
module aes_cipher_sched
  import aes_cipher_sched_pkg::*;
#(
  parameter int NK            = 8,
  parameter int NR            = 14,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  aes_cipher_sched_if.slave    bus
);

  localparam int KEY_W = 32 * NK;
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

  if (!nk_nr_legal(NK, NR)) begin : g_bad_nk_nr
    $error("aes_cipher_sched: NK/NR pair is not a legal AES configuration");
  end
  if (!settle_legal(SETTLE_CYCLES)) begin : g_bad_settle
    $error("aes_cipher_sched: SETTLE_CYCLES must be in 1..15");
  end

  state_t               state_reg, state_next;
  logic                 last_grant_reg;
  logic                 id_reg;
  logic [CNT_W-1:0]     cnt_reg;
  logic [KEY_W-1:0]     cph_key_reg;
  logic [BLOCK_W-1:0]   cph_data_reg;
  logic [BLOCK_W-1:0]   resp_data_reg;

  logic [1:0]           req_valid;
  logic [1:0]           grant;
  logic                 arb_en;
  logic                 accept;
  logic                 capture;
  logic                 resp_hs;

  assign req_valid = {bus.i_req1_valid, bus.i_req0_valid};

  aes_rr_arb u_arb (
    .valid      (req_valid),
    .last_grant (last_grant_reg),
    .enable     (arb_en),
    .grant      (grant)
  );

  always_comb begin
    state_next = state_reg;
    arb_en     = 1'b0;
    accept     = 1'b0;
    capture    = 1'b0;
    resp_hs    = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        arb_en = 1'b1;
        if (|grant) begin
          accept     = 1'b1;
          state_next = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (cnt_reg == '0) begin
          capture    = 1'b1;
          state_next = ST_RESP;
        end
      end
      ST_RESP: begin
        if (bus.i_resp_ready) begin
          resp_hs    = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg      <= ST_IDLE;
      last_grant_reg <= 1'b1;
      id_reg         <= 1'b0;
      cnt_reg        <= '0;
      cph_key_reg    <= '0;
      cph_data_reg   <= '0;
      resp_data_reg  <= '0;
    end else begin
      state_reg <= state_next;

      if (accept) begin
        cph_key_reg    <= grant[1] ? bus.i_req1_key  : bus.i_req0_key;
        cph_data_reg   <= grant[1] ? bus.i_req1_data : bus.i_req0_data;
        id_reg         <= grant[1];
        last_grant_reg <= grant[1];
        cnt_reg        <= SETTLE_LOAD;
      end else if ((state_reg == ST_SETTLE) && (cnt_reg != '0)) begin
        cnt_reg <= cnt_reg - 4'd1;
      end

      if (capture) begin
        resp_data_reg <= bus.i_cph_data;
      end

`ifdef AES_SCHED_ZEROIZE_EN
      // Scrub key material and ciphertext as soon as the consumer has taken the result.
      if (resp_hs) begin
        cph_key_reg   <= '0;
        cph_data_reg  <= '0;
        resp_data_reg <= '0;
      end
`endif
    end
  end

  assign bus.o_req0_ready = grant[0];
  assign bus.o_req1_ready = grant[1];
  assign bus.o_cph_key    = cph_key_reg;
  assign bus.o_cph_data   = cph_data_reg;
  assign bus.o_resp_valid = (state_reg == ST_RESP);
  assign bus.o_resp_id    = id_reg;
  assign bus.o_busy       = (state_reg != ST_IDLE);

`ifdef AES_SCHED_ZEROIZE_EN
  assign bus.o_resp_data = (state_reg == ST_RESP) ? resp_data_reg : '0;
`else
  assign bus.o_resp_data = resp_data_reg;
`endif

endmodule

// File: tb/tb_aes_cipher_sched.sv
// Directed bench for aes_cipher_sched with a lookup-table stand-in for the AES core.
// Known FIPS-197 AES-256 vectors are mapped exactly; other inputs use data ^ key[127:0].
module tb_aes_cipher_sched;
  import aes_cipher_sched_pkg::*;

  localparam int NK     = 8;
  localparam int NR     = 14;
  localparam int SETTLE = 2;

  localparam logic [255:0] K1 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1 = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] C0 = 128'hdc95c078a2408989ad48a21492842087;
  localparam logic [255:0] K2 = {8{32'h11111111}};
  localparam logic [127:0] P2 = 128'h0123456789abcdef0011223344556677;
  localparam logic [127:0] E2 = 128'h1032547698badcfe1100332255447766;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;
  int   both_ready_cnt = 0;

  aes_cipher_sched_if #(.NK(NK)) bus ();

  aes_cipher_sched #(
    .NK            (NK),
    .NR            (NR),
    .SETTLE_CYCLES (SETTLE)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] cipher_stub(input logic [255:0] key, input logic [127:0] data);
    if (key == K1 && data == P1) return C1;
    if (key == '0 && data == '0) return C0;
    return data ^ key[127:0];
  endfunction

  always_comb bus.i_cph_data = cipher_stub(bus.o_cph_key, bus.o_cph_data);

  always @(negedge clk) begin
    if (bus.o_req0_ready && bus.o_req1_ready) both_ready_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic         sel;
    logic [255:0] key;
    logic [127:0] data;
    logic [127:0] exp_data;
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic sel, input logic [255:0] key, input logic [127:0] data);
    if (sel) begin
      bus.i_req1_valid = 1'b1; bus.i_req1_key = key; bus.i_req1_data = data;
    end else begin
      bus.i_req0_valid = 1'b1; bus.i_req0_key = key; bus.i_req0_data = data;
    end
  endtask

  // Waits (bounded) for the expected requester's ready, then steps across the acceptance edge.
  task automatic wait_accept(input logic sel, input string name);
    int n = 0;
    #1;
    while (!(sel ? bus.o_req1_ready : bus.o_req0_ready) && n < 20) begin
      step(); #1; n++;
    end
    check({name, "_grant"}, {bus.o_req1_ready, bus.o_req0_ready}, sel ? 2'b10 : 2'b01);
    step();
  endtask

  // Called just after the acceptance edge; the handshake cycle is cycle 0, so o_resp_valid
  // must first be seen SETTLE edges later (cycle SETTLE+1).
  task automatic wait_resp(input logic id, input logic [127:0] data, input string name);
    int n = 0;
    while (!bus.o_resp_valid && n < 40) begin
      step(); n++;
    end
    check({name, "_lat"}, n, SETTLE);
    check({name, "_id"}, bus.o_resp_id, id);
    check({name, "_data"}, bus.o_resp_data, data);
    if (bus.i_resp_ready) begin
      step();
      check({name, "_vlow"}, {bus.o_resp_valid, bus.o_busy}, 2'b00);
    end
  endtask

  initial begin
    int stable_err;
    int stray;

    bus.i_req0_valid = 1'b0; bus.i_req0_key = '0; bus.i_req0_data = '0;
    bus.i_req1_valid = 1'b0; bus.i_req1_key = '0; bus.i_req1_data = '0;
    bus.i_resp_ready = 1'b1;

    vecs[0] = '{1'b0, K1,   P1,   C1};
    vecs[1] = '{1'b1, '0,   '0,   C0};
    vecs[2] = '{1'b0, '0,   '0,   C0};
    vecs[3] = '{1'b1, K1,   P1,   C1};
    vecs[4] = '{1'b0, K2,   P2,   E2};

    // Reset state
    step(); step();
    check("rst_valid", bus.o_resp_valid, 1'b0);
    check("rst_busy", bus.o_busy, 1'b0);
    check("rst_cph_key", bus.o_cph_key, '0);
    check("rst_cph_data", bus.o_cph_data, '0);
    check("rst_resp_data", bus.o_resp_data, '0);
    check("rst_resp_id", bus.o_resp_id, 1'b0);
    check("rst_readys", {bus.o_req1_ready, bus.o_req0_ready}, 2'b00);
    rst = 1'b0;

    // Single AES-256 request, then post-handshake register contents
    drive_req(1'b0, K1, P1);
    wait_accept(1'b0, "t1");
    bus.i_req0_valid = 1'b0;
    check("t1_busy", bus.o_busy, 1'b1);
    wait_resp(1'b0, C1, "t1");
`ifdef AES_SCHED_ZEROIZE_EN
    check("t6_cph_key", bus.o_cph_key, '0);
    check("t6_cph_data", bus.o_cph_data, '0);
    check("t6_resp_data", bus.o_resp_data, '0);
`else
    check("t6_cph_key", bus.o_cph_key, K1);
    check("t6_cph_data", bus.o_cph_data, P1);
`endif

    // Both valid from reset: requester 0 first, then requester 1
    rst = 1'b1; step(); rst = 1'b0;
    drive_req(1'b0, K1, P1);
    drive_req(1'b1, '0, '0);
    wait_accept(1'b0, "t2a");
    bus.i_req0_valid = 1'b0;
    wait_resp(1'b0, C1, "t2a");
    wait_accept(1'b1, "t2b");
    bus.i_req1_valid = 1'b0;
    wait_resp(1'b1, C0, "t2b");

    // Table-driven single-requester vectors
    for (int i = 0; i < 5; i++) begin
      drive_req(vecs[i].sel, vecs[i].key, vecs[i].data);
      wait_accept(vecs[i].sel, $sformatf("vec%0d", i));
      bus.i_req0_valid = 1'b0;
      bus.i_req1_valid = 1'b0;
      wait_resp(vecs[i].sel, vecs[i].exp_data, $sformatf("vec%0d", i));
    end

    // Back-pressure: response held for 20 cycles with a competing request pending
    bus.i_resp_ready = 1'b0;
    drive_req(1'b0, K1, P1);
    wait_accept(1'b0, "t3");
    bus.i_req0_valid = 1'b0;
    wait_resp(1'b0, C1, "t3");
    drive_req(1'b1, '0, '0);
    stable_err = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (!bus.o_resp_valid || bus.o_resp_data !== C1 || bus.o_resp_id !== 1'b0 ||
          bus.o_req0_ready || bus.o_req1_ready || !bus.o_busy)
        stable_err++;
    end
    check("t3_stable", stable_err, 0);
    bus.i_req1_valid = 1'b0;
    bus.i_resp_ready = 1'b1;
    step();
    check("t3_release", {bus.o_resp_valid, bus.o_busy}, 2'b00);
    step();
    check("t3_single", bus.o_resp_valid, 1'b0);

    // Reset in SETTLE
    drive_req(1'b0, K1, P1);
    wait_accept(1'b0, "t4a");
    bus.i_req0_valid = 1'b0;
    rst = 1'b1; step();
    check("t4a_ctl", {bus.o_resp_valid, bus.o_busy, bus.o_resp_id}, 3'b000);
    check("t4a_dp", {bus.o_cph_key[127:0] | bus.o_cph_key[255:128], bus.o_cph_data | bus.o_resp_data}, '0);
    rst = 1'b0;

    // Reset in RESP
    bus.i_resp_ready = 1'b0;
    drive_req(1'b0, K1, P1);
    wait_accept(1'b0, "t4b");
    bus.i_req0_valid = 1'b0;
    wait_resp(1'b0, C1, "t4b");
    rst = 1'b1; step();
    check("t4b_ctl", {bus.o_resp_valid, bus.o_busy, bus.o_resp_id}, 3'b000);
    check("t4b_dp", {bus.o_cph_key[127:0] | bus.o_cph_key[255:128], bus.o_cph_data | bus.o_resp_data}, '0);
    rst = 1'b0;
    bus.i_resp_ready = 1'b1;
    drive_req(1'b1, '0, '0);
    wait_accept(1'b1, "t4c");
    bus.i_req1_valid = 1'b0;
    wait_resp(1'b1, C0, "t4c");

    // Requester 0 pulses valid while requester 1 is in flight
    drive_req(1'b1, K1, P1);
    wait_accept(1'b1, "t5");
    bus.i_req1_valid = 1'b0;
    drive_req(1'b0, K2, P2);
    #1;
    check("t5_pulse_ready", bus.o_req0_ready, 1'b0);
    step();
    bus.i_req0_valid = 1'b0;
    // SETTLE-1 edges remain until the response appears
    begin
      int n = 0;
      while (!bus.o_resp_valid && n < 40) begin step(); n++; end
      check("t5_lat", n, SETTLE - 1);
      check("t5_id", bus.o_resp_id, 1'b1);
      check("t5_data", bus.o_resp_data, C1);
      step();
    end
    stray = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (bus.o_resp_valid || bus.o_busy) stray++;
    end
    check("t5_no_stray", stray, 0);
    // last_grant is still 1, so requester 0 wins the contention
    drive_req(1'b0, K1, P1);
    drive_req(1'b1, '0, '0);
    wait_accept(1'b0, "t5_lg");
    bus.i_req0_valid = 1'b0;
    wait_resp(1'b0, C1, "t5_lg");
    wait_accept(1'b1, "t5_lg1");
    bus.i_req1_valid = 1'b0;
    wait_resp(1'b1, C0, "t5_lg1");

    check("both_ready_never", both_ready_cnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/aes_cipher_sched.md
Name: aes_cipher_sched

Overview:
- Sequencing and arbitration controller for the shared combinational AES cipher core (key width 32*NK, 128-bit block).
- Two requesters submit key/plaintext pairs over valid/ready; a round-robin arbiter grants one.
- Key and block are registered and held on the cipher inputs for a programmable settle window. The ciphertext is then captured and returned with a requester ID over a valid/ready response channel.
- Sits between the cipher core, which is instantiated alongside it at top level, and the host-side request logic.

Parameters:
- NK, 8, key length in 32-bit words (4/6/8); passed through to the cipher core.
- NR, 14, round count matching NK; carried for top-level consistency only.
- SETTLE_CYCLES, 2, cycles the cipher inputs are held before the output is captured; legal range 1..15.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  synchronous, active-high reset.
- i_req0_valid  in  1  requester 0 has a block.
- o_req0_ready  out  1  requester 0 accepted this cycle when valid also high.
- i_req0_key  in  32*NK  requester 0 key.
- i_req0_data  in  128  requester 0 plaintext.
- i_req1_valid / o_req1_ready / i_req1_key / i_req1_data: same as requester 0, for requester 1.
- o_cph_key  out  32*NK  registered key to cipher core.
- o_cph_data  out  128  registered plaintext to cipher core.
- i_cph_data  in  128  cipher core ciphertext.
- o_resp_valid  out  1  ciphertext available.
- i_resp_ready  in  1  consumer accepts response.
- o_resp_data  out  128  ciphertext.
- o_resp_id  out  1  requester index of the response.
- o_busy  out  1  high in every state except IDLE.

Behaviour:
- Reset values: all outputs 0; state IDLE; last_grant=1, so requester 0 wins first; settle counter 0.
- Reset applies in any state; an in-flight block or pending response is discarded.
- FSM: IDLE -> SETTLE -> RESP -> IDLE.
- IDLE:
  - o_reqN_ready is combinational and high only for the granted requester.
  - Grant rule: if only one valid, grant it. If both valid, grant the one that is not last_grant.
  - Accept when valid & ready. Then latch key/data into o_cph_key/o_cph_data, latch the ID, update last_grant, load counter = SETTLE_CYCLES-1, and go to SETTLE.
  - A valid dropped before acceptance consumes no grant and does not change last_grant.
- SETTLE:
  - Cipher inputs held stable; both readys low.
  - Counter decrements each cycle.
  - In the cycle the counter is 0, capture i_cph_data into the o_resp_data register and go to RESP.
- RESP:
  - o_resp_valid high; data and ID held stable until i_resp_ready.
  - On handshake: o_resp_valid low next cycle, return to IDLE.
  - No new acceptance in the handshake cycle.
- Latency: acceptance edge = cycle 0; o_resp_valid first high in cycle SETTLE_CYCLES+1.
- Throughput: at most one block per SETTLE_CYCLES+2 cycles when i_resp_ready is held high.
- Back-pressure: RESP may last indefinitely. Requesters see ready low throughout. Request inputs are not sampled outside IDLE.
- o_cph_key/o_cph_data retain the last accepted values in IDLE, unless AES_SCHED_ZEROIZE_EN is defined.
- Widths: no arithmetic except the 4-bit settle counter; it never wraps, since it is reloaded only on acceptance.

Optional Feature:
- Macro: AES_SCHED_ZEROIZE_EN.
- Defined:
  - On the response handshake edge, clear o_cph_key, o_cph_data and the response data register to 0.
  - o_resp_data reads 0 whenever o_resp_valid is low.
- Undefined: registers retain their last values until the next acceptance.
- Either way, all registers are 0 after reset.

Decomposition:
- Shared header aes_sched_defs.vh holds:
  - FSM state encodings: IDLE=2'd0, SETTLE=2'd1, RESP=2'd2.
  - Block width constant 128.
  - Legal NK/NR pairs (4/10, 6/12, 8/14) for elaboration checks.
- One sub-module, aes_rr_arb: 2-way round-robin arbiter.
  - Inputs: valids, last_grant, enable.
  - Outputs: one-hot grant.
  - Combinational; last_grant is stored in the parent.

Test Plan:
1. Req0 only, AES-256 (NK=8, NR=14): key 000102...1f, data 00112233445566778899aabbccddeeff, i_resp_ready=1 -> o_resp_data=8ea2b7ca516745bfeafc49904b496089, o_resp_id=0, o_resp_valid rises exactly cycle 3 after acceptance (SETTLE_CYCLES=2).
2. Both valid from reset, req0 with the item-1 vector, req1 with all-zero key and data -> grant order 0 then 1. Responses are 8ea2b7ca...6089 (id 0) then dc95c078a2408989ad48a21492842087 (id 1). Readys never both high.
3. Back-pressure: i_resp_ready=0 for 20 cycles during RESP -> o_resp_valid, data and id stable, both request readys low, o_busy=1. Release -> single handshake, then IDLE.
4. Reset mid-operation: assert i_rst in SETTLE and again in RESP -> next cycle all outputs 0 and state IDLE. A subsequent req1-only request is served correctly with id 1.
5. Requester 0 pulses valid one cycle while not granted (req1 in flight) -> no response for it. last_grant is unchanged by the pulse.
6. With AES_SCHED_ZEROIZE_EN: after the item-1 handshake -> o_cph_key=0, o_cph_data=0, o_resp_data=0. Without the macro: o_cph_key and o_cph_data retain the item-1 values.
